zero_detect_arbiter: RTL



---
 rtl/zero_arb_pkg.sv | 11 +
 rtl/zero_detect_arbiter_if.sv | 13 +
 rtl/zero_detect_tree.sv | 20 ++
 rtl/zero_detect_arbiter.sv | 57 +++++
 4 files changed

// File: rtl/zero_arb_pkg.sv
// zero_arb_pkg: shared widths, requester id type and stage record for zero_detect_arbiter
package zero_arb_pkg;
  localparam int ZA_WIDTH = 64;
  localparam int ZA_NREQ = 2;
  typedef logic [0:0] za_id_t;
  typedef struct packed {
    logic valid;
    za_id_t id;
    logic [ZA_WIDTH-1:0] data;
  } za_stage_t;
endpackage

// File: rtl/zero_detect_arbiter_if.sv
// zero_detect_arbiter_if: requester bus (req, data0, data1, gnt) and result handshake (rsp_valid, rsp_id, rsp_zero, rsp_ready); slave = arbiter, master = requesters/consumer
interface zero_detect_arbiter_if import zero_arb_pkg::*; #(parameter int WIDTH = ZA_WIDTH, parameter int NREQ = ZA_NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic rsp_valid;
  za_id_t rsp_id;
  logic rsp_zero;
  logic rsp_ready;
  modport slave (input req, data0, data1, rsp_ready, output gnt, rsp_valid, rsp_id, rsp_zero);
  modport master (output req, data0, data1, rsp_ready, input gnt, rsp_valid, rsp_id, rsp_zero);
endinterface

// File: rtl/zero_detect_tree.sv
// zero_detect_tree: gate-level WIDTH-bit zero detector (data in, zero out), 4-in NOR then 4-in AND then 4-in AND per 64-bit slice
module zero_detect_tree #(parameter int WIDTH = 64) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
);
  logic [WIDTH/4-1:0] l1;
  logic [WIDTH/16-1:0] l2;
  logic [WIDTH/64-1:0] l3;
  genvar g;
  for (g = 0; g < WIDTH/4; g++) begin : g_nor
    assign l1[g] = ~|data[4*g +: 4];
  end
  for (g = 0; g < WIDTH/16; g++) begin : g_and1
    assign l2[g] = &l1[4*g +: 4];
  end
  for (g = 0; g < WIDTH/64; g++) begin : g_and2
    assign l3[g] = &l2[4*g +: 4];
  end
  assign zero = &l3;
endmodule

// File: rtl/zero_detect_arbiter.sv
// zero_detect_arbiter: round-robin (or fixed-priority with ZERO_ARB_FIXED_PRIO_EN) sharing of one zero tree; ports clk, reset, bus (slave: req/data0/data1/gnt, rsp_valid/rsp_id/rsp_zero/rsp_ready)
module zero_detect_arbiter import zero_arb_pkg::*; #(
  parameter int WIDTH = ZA_WIDTH,
  parameter int NREQ = ZA_NREQ
) (
  input logic clk,
  input logic reset,
  zero_detect_arbiter_if.slave bus
);
  logic a_valid, b_valid, b_zero, adv_a, adv_b, take, zero;
  za_id_t a_id, b_id, pick;
  logic [WIDTH-1:0] a_data;
  logic [NREQ-1:0] gnt;
`ifdef ZERO_ARB_FIXED_PRIO_EN
  assign pick = za_id_t'(!bus.req[0]);
`else
  logic ptr;
  assign pick = (&bus.req) ? ptr : za_id_t'(bus.req[1]);
  always_ff @(posedge clk)
    ptr <= reset ? 1'b0 : take ? ~pick : ptr;
`endif
  always_comb begin
    adv_b = !b_valid || bus.rsp_ready;
    adv_a = !a_valid || adv_b;
    take = adv_a && |bus.req && !reset;
    gnt = '0;
    gnt[pick] = take;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid <= 1'b0;
      a_id <= '0;
      a_data <= '0;
      b_valid <= 1'b0;
      b_id <= '0;
      b_zero <= 1'b0;
    end else begin
      if (adv_a) begin
        a_valid <= take;
        if (take) begin
          a_id <= pick;
          a_data <= pick ? bus.data1 : bus.data0;
        end
      end
      if (adv_b) begin
        b_valid <= a_valid;
        b_id <= a_id;
        b_zero <= zero;
      end
    end
  end
  zero_detect_tree #(.WIDTH(WIDTH)) u_tree (.data(a_data), .zero(zero));
  assign bus.gnt = gnt;
  assign bus.rsp_valid = b_valid;
  assign bus.rsp_id = b_id;
  assign bus.rsp_zero = b_zero;
endmodule
